// File: rtl/cla_pkg.sv
// Shared sizing and stage bookkeeping types for the pipelined CLA subtractor.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cla_pkg;

    // Lower slice is half the operand width unless overridden.
    function automatic int cla_lo_w(input int w);
        return w / 2;
    endfunction

    localparam int CLA_WIDTH = 14;
    localparam int CLA_LO_W  = cla_lo_w(CLA_WIDTH);

    // Occupancy flags of the two pipeline stage registers.
    typedef struct packed {
        logic s1;
        logic s2;
    } stage_vld_t;

endpackage

// File: rtl/cla_block.sv
// Combinational W-bit carry-lookahead adder slice: sum = a + b + cin.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; no handshake at this level.
module cla_block #(
    parameter int W = 7
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);

    logic [W-1:0] g;
    logic [W-1:0] p;
    logic [W-1:0] t;
    logic [W:0]   c;
    logic         cc;
    logic         prod;

    assign g = a & b;
    assign p = a | b;
    assign t = a ^ b;

    // Each carry is a flat sum of generate terms gated by the product of the
    // propagates above them, so no carry depends on a neighbouring carry.
    always_comb begin
        c    = '0;
        cc   = 1'b0;
        prod = 1'b1;
        for (int i = 0; i <= W; i++) begin
            cc   = 1'b0;
            prod = 1'b1;
            for (int j = i - 1; j >= 0; j--) begin
                cc   = cc | (g[j] & prod);
                prod = prod & p[j];
            end
            c[i] = cc | (cin & prod);
        end
    end

    assign sum  = t ^ c[W-1:0];
    assign cout = c[W];

endmodule

// File: rtl/cla_sub_pipe.sv
// Two-stage pipelined unsigned subtractor (min - sub) built from CLA slices.
// Latency: 2 cycles from input handshake to output handshake with i_ready high.
// Backpressure: each stage holds its result until the next accepts; o_ready drops only when both stages are full and i_ready is low.
module cla_sub_pipe
    import cla_pkg::*;
#(
    parameter int WIDTH = CLA_WIDTH,
    parameter int LO_W  = cla_lo_w(WIDTH)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_min,
    input  logic [WIDTH-1:0] i_sub,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_diff,
    output logic             o_borrow
);

    localparam int HI_W = WIDTH - LO_W;

    stage_vld_t        vld;
    logic [WIDTH-1:0]  nsub;
    logic              in_fire;
    logic              s1_en;
    logic              s2_en;

    // Stage 1 registers: lower result plus everything the upper slice needs.
    logic [LO_W-1:0]   s1_lo;
    logic              s1_carry;
    logic [HI_W-1:0]   s1_min_hi;
    logic [HI_W-1:0]   s1_nsub_hi;

    // Stage 2 registers: the complete result.
    logic [WIDTH-1:0]  s2_diff;
    logic              s2_borrow;

    logic [LO_W-1:0]   lo_sum;
    logic              lo_cout;
    logic [HI_W-1:0]   hi_sum;
    logic              hi_cout;

    // Subtraction as min + ~sub + 1; the +1 enters as carry-in of the low slice.
    assign nsub = ~i_sub;

    cla_block #(.W(LO_W)) u_lo (
        .a    (i_min[LO_W-1:0]),
        .b    (nsub[LO_W-1:0]),
        .cin  (1'b1),
        .sum  (lo_sum),
        .cout (lo_cout)
    );

    cla_block #(.W(HI_W)) u_hi (
        .a    (s1_min_hi),
        .b    (s1_nsub_hi),
        .cin  (s1_carry),
        .sum  (hi_sum),
        .cout (hi_cout)
    );

    // A stage loads when empty or when its contents leave on the same edge.
    assign s2_en   = !vld.s2 || i_ready;
    assign o_ready = !vld.s1 || !vld.s2 || i_ready;
    assign s1_en   = o_ready;
    assign in_fire = i_valid && o_ready;

    // Stage occupancy flags; reset drops any in-flight operands immediately.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            vld <= '0;
        end else begin
            if (s1_en) vld.s1 <= in_fire;
            if (s2_en) vld.s2 <= vld.s1;
        end
    end

    // Stage 1 data: capture low-slice sum, its carry-out and the upper operands.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            s1_lo      <= '0;
            s1_carry   <= 1'b0;
            s1_min_hi  <= '0;
            s1_nsub_hi <= '0;
        end else if (in_fire) begin
            s1_lo      <= lo_sum;
            s1_carry   <= lo_cout;
            s1_min_hi  <= i_min[WIDTH-1:LO_W];
            s1_nsub_hi <= nsub[WIDTH-1:LO_W];
        end
    end

    // Stage 2 data: finish the upper slice; no carry out means a borrow occurred.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            s2_diff   <= '0;
            s2_borrow <= 1'b0;
        end else if (s2_en && vld.s1) begin
            s2_diff   <= {hi_sum, s1_lo};
            s2_borrow <= ~hi_cout;
        end
    end

    assign o_valid  = vld.s2;
    assign o_diff   = s2_diff;
    assign o_borrow = s2_borrow;

endmodule
